// File: rtl/sump_meta_streamer_if.sv
// Request, abort, transmitter and status signals of the SUMP metadata streamer.
// The streamer uses the slave modport, and its environment uses the master modport.
interface sump_meta_streamer_if;
    logic       req_valid;
    logic       req_sel;
    logic       req_ready;
    logic       abort;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [5:0] byte_cnt;

    modport slave (
        input  req_valid, req_sel, abort, tx_busy,
        output req_ready, tx_start, tx_byte, busy, done, aborted, byte_cnt
    );

    modport master (
        output req_valid, req_sel, abort, tx_busy,
        input  req_ready, tx_start, tx_byte, busy, done, aborted, byte_cnt
    );
endinterface

// File: rtl/sump_meta_streamer.sv
// SUMP response generator: streams the device ID or the metadata block byte by byte
// into a UART transmitter, using a start/busy handshake and supporting abort.
module sump_meta_streamer #(
    parameter int                  NAME_LEN    = 16,
    parameter logic [8*NAME_LEN-1:0] DEV_NAME  = "LogicAnalyzer v2",
    parameter int                  FW_LEN      = 4,
    parameter logic [8*FW_LEN-1:0] FW_VER      = "2.00",
    parameter logic [31:0]         MEM_BYTES   = 32'h0000_8000,
    parameter logic [31:0]         MAX_RATE_HZ = 32'd200_000_000,
    parameter logic [7:0]          NUM_PROBES  = 8'd8,
    parameter logic [7:0]          PROTO_VER   = 8'd2,
    parameter logic [31:0]         ID_WORD     = 32'h3141_4C53,
    parameter int                  ACK_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    sump_meta_streamer_if.slave   bus
);

    localparam int LEN_M = NAME_LEN + FW_LEN + 19;
    localparam int LEN_I = 4;
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [5:0] LAST_M = 6'(LEN_M - 1);
    localparam logic [5:0] LAST_I = 6'(LEN_I - 1);

    // Whole metadata block, byte 0 in the most significant position.
    localparam logic [8*LEN_M-1:0] META = {
        8'h01, DEV_NAME, 8'h00,
        8'h02, FW_VER, 8'h00,
        8'h21, MEM_BYTES,
        8'h23, MAX_RATE_HZ,
        8'h40, NUM_PROBES,
        8'h41, PROTO_VER,
        8'h00
    };

    if (NAME_LEN < 1 || NAME_LEN > 32) begin : g_bad_name_len
        $error("sump_meta_streamer: NAME_LEN must be 1..32");
    end
    if (FW_LEN < 1 || FW_LEN > 16) begin : g_bad_fw_len
        $error("sump_meta_streamer: FW_LEN must be 1..16");
    end
    if (LEN_M > 63) begin : g_bad_meta_len
        $error("sump_meta_streamer: metadata image longer than 63 bytes");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("sump_meta_streamer: ACK_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    function automatic logic [7:0] image_byte(input logic sel, input logic [5:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (sel) begin
            b = ID_WORD[(3 - int'(idx[1:0])) * 8 +: 8];
        end else if (int'(idx) < LEN_M) begin
            b = META[(LEN_M - 1 - int'(idx)) * 8 +: 8];
        end
        return b;
    endfunction

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic [5:0]       ptr_q, ptr_d;
    logic [5:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             busy_q, busy_d;
    logic             aborted_q, aborted_d;
    logic             abort_q, abort_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic accept;
    logic last_byte;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        aborted_d  = aborted_q;
        abort_d    = abort_q;
        tmo_d      = tmo_q;

        accept    = (state_q == S_IDLE) && bus.req_valid && !bus.tx_busy;
        last_byte = (ptr_q == (sel_q ? LAST_I : LAST_M));

        if (busy_q && bus.abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sel_d      = bus.req_sel;
                    ptr_d      = 6'd0;
                    byte_cnt_d = 6'd0;
                    aborted_d  = 1'b0;
                    abort_d    = 1'b0;
                    busy_d     = 1'b1;
                    tx_byte_d  = image_byte(bus.req_sel, 6'd0);
                    state_d    = S_START;
                end
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // A transmitter that never reports busy still gets the byte counted as sent.
                if (bus.tx_busy || tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    byte_cnt_d = (byte_cnt_q == 6'd63) ? byte_cnt_q : byte_cnt_q + 6'd1;
                    if (last_byte) begin
                        // A completed stream is never reported as aborted.
                        aborted_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = S_FINISH;
                    end else if (abort_q || bus.abort) begin
                        aborted_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = S_FINISH;
                    end else begin
                        ptr_d     = ptr_q + 6'd1;
                        tx_byte_d = image_byte(sel_q, ptr_q + 6'd1);
                        state_d   = S_START;
                    end
                end
            end
            S_FINISH: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            ptr_q      <= 6'd0;
            byte_cnt_q <= 6'd0;
            tx_byte_q  <= 8'h00;
            busy_q     <= 1'b0;
            aborted_q  <= 1'b0;
            abort_q    <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            aborted_q  <= aborted_d;
            abort_q    <= abort_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE) && !bus.tx_busy;
    assign bus.tx_start  = (state_q == S_START);
    assign bus.tx_byte   = tx_byte_q;
    assign bus.busy      = busy_q;
    assign bus.done      = (state_q == S_FINISH);
    assign bus.aborted   = aborted_q;
    assign bus.byte_cnt  = byte_cnt_q;

endmodule
